axi_lite_initiator: RTL
=======================

Name: axi_lite_initiator

Overview:
- Single-outstanding AXI4-Lite initiator (master) for the SoC testbench and peripheral paths.
- Converts a simple valid/ready request/response interface into AXI4-Lite read or write transactions.
- Drives the same AW/W/B/AR/R channel set that axi_memory responds to, so a bench can exercise the memory model without the CPU.
- One transaction in flight at a time; the response is held until the consumer accepts it.

Parameters:
- ADDR_WIDTH, 32, AXI address width in bits.
- DATA_WIDTH, 32, AXI data width in bits; wstrb width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  write data
- req_wstrb  in  DATA_WIDTH/8  write byte strobes; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high together with rsp_valid
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  AXI response code (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3)
- axi_awaddr/axi_awvalid/axi_awready, axi_wdata/axi_wstrb/axi_wvalid/axi_wready, axi_bresp/axi_bvalid/axi_bready, axi_araddr/axi_arvalid/axi_arready, axi_rdata/axi_rresp/axi_rvalid/axi_rready  standard AXI4-Lite; directions are the initiator side.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. This covers req_ready, rsp_valid, rsp_rdata, rsp_resp, every axi_*valid, axi_bready, axi_rready and all address/data registers.
- Reset mid-transaction drops every valid immediately (asynchronously); the transaction is discarded with no response.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr/wdata/wstrb/write.
  - Go to RD_ADDR (read) or WR_REQ (write).
- RD_ADDR:
  - axi_arvalid=1 with a stable axi_araddr.
  - On axi_arready, go to RD_DATA.
- RD_DATA:
  - axi_rready=1.
  - On axi_rvalid, capture rdata/rresp and go to RSP.
- WR_REQ:
  - axi_awvalid and axi_wvalid rise in the same cycle.
  - Each valid drops independently on its own handshake; the done flags are tracked separately.
  - Go to WR_RESP in the cycle after both handshakes are complete. This includes both handshakes occurring in the same cycle.
- WR_RESP:
  - axi_bready=1.
  - On axi_bvalid, capture bresp, set rsp_rdata=0, go to RSP.
- RSP:
  - rsp_valid=1; outputs are held stable until rsp_ready, then return to IDLE.
  - req_ready stays 0 until IDLE, so there are no back-to-back accepts without a bubble.
- Latency with a zero-wait responder:
  - Accept at cycle T, arvalid at T+1, rready at T+2, rsp_valid at T+3.
  - A write has the same latency: awvalid/wvalid at T+1, bready at T+2, rsp_valid at T+3.
- A valid, once asserted, is never withdrawn before its ready, except on reset or watchdog abort.
- Address and data pass through unmodified; no alignment check.
- Non-OKAY responses are forwarded verbatim in rsp_resp. For reads, rsp_rdata carries axi_rdata even on error.

Optional Feature:
- Macro: AXI_LITE_INITIATOR_TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to RD_ADDR/WR_REQ and runs through the wait states.
  - When it reaches TIMEOUT_CYCLES, all valids/readies drop and the block goes to RSP with rsp_resp=DECERR and rsp_rdata=0.
  - This is a deliberate, bench-only protocol abort.
- Undefined: no counter is built and the block waits indefinitely.

Decomposition:
- Shared package kcore_axi_pkg:
  - axi_resp_t enum: OKAY, EXOKAY, SLVERR, DECERR.
  - axi_init_state_t enum: the six states above.
  - Constant AXI_RESP_W=2.
- Single module; no sub-module is needed. The timeout counter is inline, under the macro.

Test Plan:
- Write 0x0000_1000 = 0xDEADBEEF, wstrb 4'hF, against axi_memory with latency 1 → rsp_resp=0. A following read of 0x1000 returns rsp_rdata=0xDEADBEEF.
- Write 0x1004 = 0x11223344 with wstrb 4'b0101 over an existing 0xFFFFFFFF → read back 0xFF22FF44.
- Responder asserts wready 3 cycles before awready → axi_wvalid drops alone first, a single B handshake follows, and exactly one rsp_valid is produced.
- Hold rsp_ready=0 for 5 cycles after a read → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; accepted on the 6th cycle.
- Assert rst while axi_arvalid=1 → arvalid is 0 immediately (same cycle), state returns to IDLE, no rsp_valid.
- With the macro defined and TIMEOUT_CYCLES=16, a responder that never raises arready → after 16 cycles arvalid=0, rsp_valid=1, rsp_resp=3, rsp_rdata=0.

Source files
------------

// File: rtl/kcore_axi_pkg.sv
// ---------------------------------------------------------------------------
// kcore_axi_pkg
// Purpose : Shared AXI4-Lite definitions for the kcore initiator and memory
//           paths: the response code encoding and the initiator FSM states.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package kcore_axi_pkg;

  localparam int AXI_RESP_W = 2;

  typedef enum logic [AXI_RESP_W-1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } axi_init_state_t;

endpackage

// File: rtl/axi_lite_initiator.sv
// ---------------------------------------------------------------------------
// axi_lite_initiator
// Purpose : Single-outstanding AXI4-Lite master. A valid/ready request is
//           turned into one AXI read or write; the response is held on the
//           rsp_* interface until the consumer accepts it.
// Ports   : clk, rst (async, active-high)
//           req_valid/req_ready/req_write/req_addr/req_wdata/req_wstrb
//           rsp_valid/rsp_ready/rsp_rdata/rsp_resp
//           axi_aw*, axi_w*, axi_b*, axi_ar*, axi_r* (initiator side)
// Options : define AXI_LITE_INITIATOR_TIMEOUT_EN to build a watchdog that
//           aborts a stalled transaction after TIMEOUT_CYCLES with DECERR.
// ---------------------------------------------------------------------------
module axi_lite_initiator
  import kcore_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [AXI_RESP_W-1:0]   rsp_resp,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  input  logic [AXI_RESP_W-1:0]   axi_bresp,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [DATA_WIDTH-1:0]   axi_rdata,
  input  logic [AXI_RESP_W-1:0]   axi_rresp,
  input  logic                    axi_rvalid,
  output logic                    axi_rready
);

  axi_init_state_t state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic aw_done;
  logic w_done;
  logic aw_fire;
  logic w_fire;
  logic timeout_hit;

  // One address register serves both channels; only one of them is ever
  // valid for a given transaction.
  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;

  assign aw_fire = axi_awvalid && axi_awready;
  assign w_fire  = axi_wvalid && axi_wready;

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic in_wait;

  assign in_wait = (state == RD_ADDR) || (state == RD_DATA) ||
                   (state == WR_REQ)  || (state == WR_RESP);
  // Fires on the last of TIMEOUT_CYCLES cycles spent waiting, so the
  // valids are visible for exactly TIMEOUT_CYCLES cycles before the abort.
  assign timeout_hit = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle so it starts from zero on entry to RD_ADDR/WR_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Main FSM; every interface output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      addr_q      <= '0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else if (timeout_hit) begin
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_rready  <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= DECERR;
      rsp_valid   <= 1'b1;
      state       <= RSP;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            addr_q    <= req_addr;
            axi_wdata <= req_wdata;
            axi_wstrb <= req_wstrb;
            if (req_write) begin
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_REQ;
            end else begin
              axi_arvalid <= 1'b1;
              state       <= RD_ADDR;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_rdata  <= axi_rdata;
            rsp_resp   <= axi_rresp;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        WR_REQ: begin
          // AW and W may complete in any order or together; the current
          // cycle's handshakes are folded in so no extra cycle is lost.
          if (aw_fire) begin
            axi_awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_fire) begin
            axi_wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            axi_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_rdata  <= '0;
            rsp_resp   <= axi_bresp;
            rsp_valid  <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
